// File: rtl/pkt_pkg.sv
// Shared packet definitions for the router injection path: field widths,
// bit positions, packed packet layout, opcodes and slot state encoding.
package pkt_pkg;

    localparam int ADDR_W  = 4;
    localparam int OP_W    = 4;
    localparam int DATA_W  = 25;
    localparam int PKT_W   = ADDR_W + OP_W + DATA_W;

    localparam int ADDR_HI = 32;
    localparam int ADDR_LO = 29;
    localparam int OP_HI   = 28;
    localparam int OP_LO   = 25;
    localparam int DATA_HI = 24;
    localparam int DATA_LO = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 4'h0,
        OP_FILTER  = 4'h1,
        OP_IFMAP   = 4'h2,
        OP_PSUM    = 4'h3,
        OP_MEM_RD  = 4'h4
    } opcode_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr (mod
// NUM_REQ) wins; one-hot grant plus encoded index, all-zero when disabled.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = SRC_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/pkt_inject_arbiter.sv
// Round-robin injection arbiter with a one-entry output slot in front of the
// router port. Define PKT_INJECT_STATS_EN to add delivery/stall counters.
module pkt_inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = pkt_pkg::ADDR_W,
    parameter int OP_W    = pkt_pkg::OP_W,
    parameter int DATA_W  = pkt_pkg::DATA_W,
    parameter int PKT_W   = ADDR_W + OP_W + DATA_W,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [PKT_W-1:0]          pkt_data,
    output logic [SRC_W-1:0]          pkt_src,
`ifdef PKT_INJECT_STATS_EN
    output logic [NUM_REQ*16-1:0]     pkt_count,
    output logic [15:0]               stall_cycles,
`endif
    output logic                      busy
);

    import pkt_pkg::*;

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][OP_W-1:0]   op_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_a;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign op_a[i]   = req_opcode[i*OP_W +: OP_W];
        assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    end

    slot_state_e        state, state_nxt;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               can_load, accept, drain;

    assign pkt_valid = (state == SLOT_FULL);
    assign drain     = pkt_valid & pkt_ready;
    assign can_load  = (state == SLOT_EMPTY) | drain;

    // Gating with rst_n keeps req_ready low while reset is held.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (can_load & rst_n),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign busy      = pkt_valid | (|req_valid);

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = SLOT_FULL;
        else if (drain)
            state_nxt = SLOT_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SLOT_EMPTY;
        else
            state <= state_nxt;
    end

    // Payload is only written on accept; a plain drain leaves stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_data <= '0;
            pkt_src  <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            pkt_data <= {addr_a[gnt_idx], op_a[gnt_idx], data_a[gnt_idx]};
            pkt_src  <= gnt_idx;
            rr_ptr   <= (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : gnt_idx + SRC_W'(1);
        end
    end

`ifdef PKT_INJECT_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt;
    logic [15:0]              stall_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt[i] <= '0;
            else if (drain && pkt_src == SRC_W'(i) && cnt[i] != 16'hFFFF)
                cnt[i] <= cnt[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (pkt_valid && !pkt_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign pkt_count    = cnt;
    assign stall_cycles = stall_q;
`endif

endmodule
